// File: rtl/serialize_word_to_bit_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : serialize_word_to_bit_stream                                 |
// | Brief   : Accepts variable-length parallel words over valid/ready and  |
// |           emits them one bit per clock on a single serial line, with a |
// |           one-entry holding register for gap-free streaming.           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module serialize_word_to_bit_stream #(
   parameter int W         = 8,
   parameter bit LSB_FIRST = 1'b0,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   up_valid,
   output logic                   up_ready,
   input  logic [W-1:0]           up_data,
   input  logic [$clog2(W+1)-1:0] up_len,
   output logic                   a,
   output logic                   a_valid,
   output logic                   word_done,
   output logic                   busy
);

   localparam int LW = $clog2(W+1);
   localparam logic [LW-1:0] c_W_LEN = LW'(W);
   localparam logic [LW-1:0] c_ONE   = LW'(1);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_hold_valid;
   logic [W-1:0]    r_hold_data;
   logic [LW-1:0]   r_hold_len;

   logic [W-1:0]    r_shreg;
   logic [LW-1:0]   r_rem;

   logic            r_a;
   logic            r_a_valid;
   logic            r_word_done;

   logic            w_xfer;
   logic            w_load;
   logic            w_last;
   logic [LW-1:0]   w_eff_len;
   logic            w_cur_bit;
   logic [W-1:0]    w_shreg_adv;
   logic [W-1:0]    w_load_word;

   // up_ready depends only on the registered hold flag (and reset), never on up_valid
   assign up_ready  = ~r_hold_valid & ~rst;
   assign w_xfer    = up_valid & up_ready;
   assign w_eff_len = (up_len > c_W_LEN) ? c_W_LEN : up_len;

   // Bit ordering: MSB-first words are left-aligned at load so bit len-1 leads
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign w_cur_bit   = r_shreg[0];
         assign w_shreg_adv = r_shreg >> 1;
         assign w_load_word = r_hold_data;
      end else begin : g_msb_first
         assign w_cur_bit   = r_shreg[W-1];
         assign w_shreg_adv = r_shreg << 1;
         assign w_load_word = r_hold_data << (c_W_LEN - r_hold_len);
      end
   endgenerate

   // Next-state: load from hold when the shifter is empty or on its last bit
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = (r_state == S_SHIFT) && (r_rem == c_ONE);
      if (((r_state == S_EMPTY) || w_last) && r_hold_valid) begin
         w_load      = 1'b1;
         // zero-length words are dropped here without producing bits
         w_state_nxt = (r_hold_len != '0) ? S_SHIFT : S_EMPTY;
      end else if (w_last) begin
         w_state_nxt = S_EMPTY;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Holding register: fills on transfer, drains on load (never both at once)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_hold_len   <= '0;
      end else if (w_load) begin
         r_hold_valid <= 1'b0;
      end else if (w_xfer) begin
         r_hold_valid <= 1'b1;
         r_hold_data  <= up_data;
         r_hold_len   <= w_eff_len;
      end
   end

   // Shifter datapath and registered serial outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg     <= '0;
         r_rem       <= '0;
         r_a         <= IDLE_BIT;
         r_a_valid   <= 1'b0;
         r_word_done <= 1'b0;
      end else begin
         if (r_state == S_SHIFT) begin
            r_a         <= w_cur_bit;
            r_a_valid   <= 1'b1;
            r_word_done <= (r_rem == c_ONE);
         end else begin
            r_a         <= IDLE_BIT;
            r_a_valid   <= 1'b0;
            r_word_done <= 1'b0;
         end
         if (w_load) begin
            r_shreg <= w_load_word;
            r_rem   <= r_hold_len;
         end else if (r_state == S_SHIFT) begin
            r_shreg <= w_shreg_adv;
            r_rem   <= r_rem - c_ONE;
         end
      end
   end

   assign a         = r_a;
   assign a_valid   = r_a_valid;
   assign word_done = r_word_done;
   assign busy      = r_hold_valid | (r_state == S_SHIFT) | r_a_valid;

endmodule
`default_nettype wire

// File: tb/tb_serialize_word_to_bit_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_serialize_word_to_bit_stream                              |
// | Brief   : Scoreboard bench for serialize_word_to_bit_stream; drives an |
// |           MSB-first and an LSB-first instance with identical stimulus. |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_serialize_word_to_bit_stream;

   localparam int W    = 8;
   localparam int LW   = $clog2(W+1);
   localparam bit IDLE = 1'b0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          up_valid = 1'b0;
   logic [W-1:0]  up_data = '0;
   logic [LW-1:0] up_len = '0;

   logic rdy_m, a_m, av_m, wd_m, busy_m;
   logic rdy_l, a_l, av_l, wd_l, busy_l;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   exp_t q_m[$];
   exp_t q_l[$];

   int n_cmp = 0, n_err = 0, cyc = 0;
   int vcount = 0, wdcount = 0, first_v = -1, last_v = -1;
   int max_gap = 0, run = 0, max_run = 0, xfer_cyc = 0;

   serialize_word_to_bit_stream #(.W(W), .LSB_FIRST(1'b0), .IDLE_BIT(IDLE)) u_msb (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(rdy_m),
      .up_data(up_data), .up_len(up_len), .a(a_m), .a_valid(av_m),
      .word_done(wd_m), .busy(busy_m));

   serialize_word_to_bit_stream #(.W(W), .LSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_lsb (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(rdy_l),
      .up_data(up_data), .up_len(up_len), .a(a_l), .a_valid(av_l),
      .word_done(wd_l), .busy(busy_l));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference model: expected serial bits of one word, both orderings
   function automatic void push_word(input logic [W-1:0] d, input int len);
      int eff = (len > W) ? W : len;
      for (int i = 0; i < eff; i++) begin
         exp_t e;
         e.last = (i == eff - 1);
         e.b    = d[eff-1-i];
         q_m.push_back(e);
         e.b    = d[i];
         q_l.push_back(e);
      end
   endfunction

   // Monitor: compares every emitted bit against the scoreboard queues
   always @(negedge clk) begin
      exp_t e;
      if (av_m) begin
         if (q_m.size() == 0) chk("msb_unexpected_bit", 1, 0);
         else begin
            e = q_m.pop_front();
            chk("msb_bit", a_m, e.b);
            chk("msb_word_done", wd_m, e.last);
         end
         vcount++;
         if (wd_m) wdcount++;
         if (first_v < 0) first_v = cyc;
         if (last_v >= 0 && (cyc - last_v - 1) > max_gap) max_gap = cyc - last_v - 1;
         last_v = cyc;
         run++;
         if (run > max_run) max_run = run;
      end else begin
         chk("msb_idle_a", a_m, IDLE);
         chk("msb_idle_word_done", wd_m, 0);
         run = 0;
      end
      if (av_l) begin
         if (q_l.size() == 0) chk("lsb_unexpected_bit", 1, 0);
         else begin
            e = q_l.pop_front();
            chk("lsb_bit", a_l, e.b);
            chk("lsb_word_done", wd_l, e.last);
         end
      end else begin
         chk("lsb_idle_a", a_l, IDLE);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a word and hold it until accepted; returns cycles spent with up_ready low
   task automatic send(input logic [W-1:0] d, input int len, output int waits);
      logic rdy;
      int   g;
      g     = 0;
      waits = 0;
      rdy   = 1'b0;
      up_valid = 1'b1;
      up_data  = d;
      up_len   = LW'(len);
      do begin
         @(negedge clk);
         rdy = rdy_m;
         if (!rdy) waits++;
         @(posedge clk);
         g++;
      end while (!rdy && g < 200);
      #1;
      up_valid = 1'b0;
      if (!rdy) chk("send_timeout", 0, 1);
      else begin
         xfer_cyc = cyc;
         push_word(d, len);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((q_m.size() != 0 || q_l.size() != 0 || busy_m || busy_l) && g < 300) begin
         tick(1);
         g++;
      end
      if (g >= 300) chk("drain_timeout", 0, 1);
      tick(2);
   endtask

   initial begin
      int w, v0, wd0;
      #1;
      chk("reset_a", a_m, IDLE);
      chk("reset_a_valid", av_m, 0);
      chk("reset_word_done", wd_m, 0);
      chk("reset_busy", busy_m, 0);
      chk("reset_up_ready", rdy_m, 0);
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_release", rdy_m, 1);
      tick(1);

      // single word, latency and bit pattern
      first_v = -1; v0 = vcount; wd0 = wdcount;
      send(8'h33, 6, w);
      drain();
      chk("latency", first_v - xfer_cyc, 2);
      chk("len6_bits", vcount - v0, 6);
      chk("len6_word_done", wdcount - wd0, 1);

      // back-to-back streaming
      max_run = 0; wd0 = wdcount;
      send(8'hA5, 8, w);
      send(8'h0F, 4, w);
      chk("b2b_ready_low_cycles", w, 1);
      drain();
      chk("b2b_contiguous_bits", max_run, 12);
      chk("b2b_word_done", wdcount - wd0, 2);

      // zero length
      v0 = vcount; wd0 = wdcount;
      send(8'hFF, 0, w);
      drain();
      chk("len0_bits", vcount - v0, 0);
      chk("len0_word_done", wdcount - wd0, 0);

      // over-length clamps to W
      v0 = vcount;
      send(8'hFF, 15, w);
      drain();
      chk("len15_bits", vcount - v0, 8);

      // LSB-first example word
      send(8'h03, 6, w);
      drain();

      // length-1 words: at most one idle cycle between them
      last_v = -1; max_gap = 0; v0 = vcount;
      for (int i = 0; i < 4; i++) send(W'($urandom), 1, w);
      drain();
      chk("len1_max_gap", (max_gap <= 1) ? 1 : 0, 1);
      chk("len1_bits", vcount - v0, 4);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         send(W'($urandom), int'($urandom_range(0, 15)), w);
         if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(1, 3)));
      end
      drain();

      // reset in the middle of a word with another word in hold
      v0 = vcount;
      send(8'hB7, 8, w);
      send(8'h5A, 8, w);
      begin
         int g;
         g = 0;
         while ((vcount - v0) < 3 && g < 50) begin
            @(negedge clk);
            g++;
         end
         if (g >= 50) chk("mid_reset_wait_timeout", 0, 1);
      end
      #2 rst = 1'b1;
      #1;
      chk("mid_reset_a", a_m, IDLE);
      chk("mid_reset_a_valid", av_m, 0);
      chk("mid_reset_busy", busy_m, 0);
      chk("mid_reset_word_done", wd_m, 0);
      q_m.delete();
      q_l.delete();
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_reset_ready", rdy_m, 1);
      v0 = vcount;
      tick(20);
      chk("no_stale_bits", vcount - v0, 0);
      chk("post_reset_busy", busy_m, 0);

      // a final word after reset still works
      send(8'hC3, 8, w);
      drain();
      chk("msb_queue_empty", q_m.size(), 0);
      chk("lsb_queue_empty", q_l.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
